// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: command-driven sequencer owning a BW-bit wrap-around count register
module counter_seq_ctrl #(
   parameter int BW    = 3,
   parameter int CYC_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [1:0]       cmd_op_i,
   input  logic [CYC_W-1:0] cmd_arg_i,
   input  logic             abort_i,
   output logic [BW-1:0]    counter_val_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             aborted_o,
   output logic             wrap_o
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2} state_t;
   localparam logic [1:0] OP_LOAD = 2'b10;
   localparam logic [1:0] OP_HOLD = 2'b11;
   state_t           state_q, state_d;
   logic [CYC_W-1:0] rem_q, rem_d;
   logic [BW-1:0]    cnt_q, cnt_d;
   logic             dn_q, dn_d, done_q, done_d, abrt_q, abrt_d, wrap_q, wrap_d;
   // state and registered pulse flops
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         cnt_q   <= '0;
         dn_q    <= 1'b0;
         done_q  <= 1'b0;
         abrt_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         dn_q    <= dn_d;
         done_q  <= done_d;
         abrt_q  <= abrt_d;
         wrap_q  <= wrap_d;
      end
   end
   // next state: accept in IDLE, step/hold while active, abort beats the final step
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      dn_d    = dn_q;
      done_d  = 1'b0;
      abrt_d  = 1'b0;
      wrap_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               if (cmd_op_i == OP_LOAD) begin
                  cnt_d  = cmd_arg_i[BW-1:0];
                  done_d = 1'b1;
               end else if (cmd_arg_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = (cmd_op_i == OP_HOLD) ? S_HOLD : S_RUN;
                  rem_d   = cmd_arg_i;
                  dn_d    = cmd_op_i[0];
               end
            end
         end
         default: begin
            if (abort_i) begin
               state_d = S_IDLE;
               rem_d   = '0;
               done_d  = 1'b1;
               abrt_d  = 1'b1;
            end else begin
               if (state_q == S_RUN) begin
                  cnt_d  = dn_q ? cnt_q - 1'b1 : cnt_q + 1'b1;
                  wrap_d = dn_q ? (cnt_q == '0) : (cnt_q == '1);
               end
               rem_d = rem_q - 1'b1;
               if (rem_q == CYC_W'(1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
      endcase
   end
   // outputs decoded from state and pulse flops
   always_comb begin
      cmd_ready_o   = (state_q == S_IDLE);
      busy_o        = (state_q != S_IDLE);
      counter_val_o = cnt_q;
      done_o        = done_q;
      aborted_o     = abrt_q;
      wrap_o        = wrap_q;
   end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: randomized command bench with a per-command arithmetic reference model
module tb_counter_seq_ctrl;
   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       cmd_valid_i = 1'b0;
   logic       cmd_ready_o;
   logic [1:0] cmd_op_i = 2'd0;
   logic [7:0] cmd_arg_i = 8'd0;
   logic       abort_i = 1'b0;
   logic [2:0] counter_val_o;
   logic       busy_o, done_o, aborted_o, wrap_o;
   int         checks = 0;
   int         errors = 0;
   int         mval = 0;

   counter_seq_ctrl #(.BW(3), .CYC_W(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_op_i(cmd_op_i), .cmd_arg_i(cmd_arg_i), .abort_i(abort_i),
      .counter_val_o(counter_val_o), .busy_o(busy_o), .done_o(done_o),
      .aborted_o(aborted_o), .wrap_o(wrap_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_all(input string tag, input int v, input bit bz, input bit dn, input bit ab, input bit wr);
      chk({tag, "_val"}, counter_val_o, v);
      chk({tag, "_busy"}, busy_o, bz);
      chk({tag, "_ready"}, cmd_ready_o, !bz);
      chk({tag, "_done"}, done_o, dn);
      chk({tag, "_aborted"}, aborted_o, ab);
      chk({tag, "_wrap"}, wrap_o, wr);
   endtask

   // op/arg issued with valid for one edge; ab = step index at which abort_i is raised (0 = never)
   task automatic do_cmd(input logic [1:0] op, input logic [7:0] arg, input int ab);
      int  n;
      bit  we;
      chk("ready_pre", cmd_ready_o, 1);
      cmd_valid_i = 1'b1;
      cmd_op_i    = op;
      cmd_arg_i   = arg;
      abort_i     = 1'($urandom_range(0, 1));
      tick();
      cmd_valid_i = 1'b0;
      cmd_op_i    = 2'($urandom);
      cmd_arg_i   = 8'($urandom);
      abort_i     = 1'b0;
      if (op == 2'b10) begin
         mval = arg % 8;
         chk_all("load", mval, 0, 1, 0, 0);
         return;
      end
      n = arg;
      if (n == 0) begin
         chk_all("zero", mval, 0, 1, 0, 0);
         return;
      end
      chk_all("accept", mval, 1, 0, 0, 0);
      for (int k = 1; k <= n; k++) begin
         abort_i = (k == ab);
         tick();
         abort_i = 1'b0;
         if (k == ab) begin
            chk_all("abort", mval, 0, 1, 1, 0);
            return;
         end
         we = 0;
         if (op == 2'b00) begin
            we = (mval == 7);
            mval = (mval + 1) % 8;
         end else if (op == 2'b01) begin
            we = (mval == 0);
            mval = (mval + 7) % 8;
         end
         chk_all(op == 2'b11 ? "hold" : "step", mval, k != n, k == n, 0, we);
      end
   endtask

   initial begin
      logic [1:0] op;
      logic [7:0] arg;
      int         ab;
      cmd_valid_i = 1'b1;
      cmd_op_i    = 2'b10;
      cmd_arg_i   = 8'd5;
      repeat (3) tick();
      chk_all("reset", 0, 0, 0, 0, 0);
      cmd_valid_i = 1'b0;
      rst_i = 1'b0;
      tick();
      chk_all("post_reset", 0, 0, 0, 0, 0);
      do_cmd(2'b00, 8'd10, 0);
      chk("run_up10_final", counter_val_o, 2);
      do_cmd(2'b10, 8'd5, 0);
      do_cmd(2'b01, 8'd7, 0);
      chk("run_dn7_final", counter_val_o, 6);
      do_cmd(2'b11, 8'd4, 0);
      do_cmd(2'b00, 8'd20, 5);
      do_cmd(2'b00, 8'd0, 0);
      do_cmd(2'b11, 8'd3, 2);
      do_cmd(2'b00, 8'd3, 3);
      do_cmd(2'b01, 8'd255, 0);
      tick();
      chk_all("idle_gap", mval, 0, 0, 0, 0);
      cmd_valid_i = 1'b1;
      cmd_op_i    = 2'b00;
      cmd_arg_i   = 8'd20;
      tick();
      cmd_valid_i = 1'b0;
      repeat (5) tick();
      #2 rst_i = 1'b1;
      #1;
      mval = 0;
      chk_all("mid_reset", 0, 0, 0, 0, 0);
      tick();
      rst_i = 1'b0;
      tick();
      chk_all("after_mid_reset", 0, 0, 0, 0, 0);
      for (int i = 0; i < 80; i++) begin
         op  = 2'($urandom);
         arg = (op == 2'b10) ? 8'($urandom) : 8'($urandom_range(0, 12));
         ab  = (arg != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, arg)) : 0;
         do_cmd(op, arg, ab);
         if ($urandom_range(0, 2) == 0) begin
            tick();
            chk_all("rand_gap", mval, 0, 0, 0, 0);
         end
      end
      tick();
      chk("final_done_low", done_o, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
